// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for the EX stage: one bit per cycle,
// signed and unsigned, with the {hi,lo} result feeding the HI/LO registers.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               dbz_o
);

    typedef enum logic [1:0] {IDLE, DIVZ, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_mul;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] final_res;

    // Magnitudes and signs of the incoming operands, used only at the start edge.
    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & opdata1_i[WIDTH-1];
        b_neg     = signed_op & opdata2_i[WIDTH-1];
        abs1      = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2      = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // One iteration: restoring shift-subtract for divide, shift-add for multiply.
    always_comb begin
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opa};
        sum     = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opa}) : {1'b0, acc_hi};
        if (is_mul) begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end
        product = {nxt_hi, nxt_lo};
        if (is_mul)
            final_res = neg_q ? (~product + 1'b1) : product;
        else
            final_res = {neg_r ? (~nxt_hi + 1'b1) : nxt_hi,
                         neg_q ? (~nxt_lo + 1'b1) : nxt_lo};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_mul   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opa      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
            dbz_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!annul_i && start_i) begin
                        is_mul <= op_i[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        acc_hi <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (op_i[1]) begin
                            opa    <= abs1;
                            acc_lo <= abs2;
                        end else begin
                            opa    <= abs2;
                            acc_lo <= abs1;
                        end
                        state <= (!op_i[1] && opdata2_i == '0) ? DIVZ : CALC;
                    end
                end
                // Zero divisor spends two cycles here so ready appears at E0+2.
                DIVZ: begin
                    if (annul_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (cnt != '0) begin
                        state    <= DONE;
                        result_o <= '0;
                        dbz_o    <= 1'b1;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CALC: begin
                    if (annul_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= DONE;
                            result_o <= final_res;
                            ready_o  <= 1'b1;
                            dbz_o    <= 1'b0;
                            busy_o   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [1:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        dbz_o;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] res8;
    logic        ready8;
    logic        busy8;
    logic        dbz8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o),
        .ready_o(ready_o), .busy_o(busy_o), .dbz_o(dbz_o)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(1'b0), .op_i(op8),
        .opdata1_i(a8), .opdata2_i(b8), .result_o(res8),
        .ready_o(ready8), .busy_o(busy8), .dbz_o(dbz8)
    );

    // Reference model: {dbz, result} from ordinary 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q;
        longint          r;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        case (op)
            2'b00: begin
                if (b == 0) return {1'b1, 64'd0};
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            2'b01: begin
                if (b == 0) return {1'b1, 64'd0};
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            2'b10: res = 64'(sa * sb);
            default: res = 64'(ua * ub);
        endcase
        return {1'b0, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Run one full operation: start, scramble inputs, wait for ready, hold, release.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [64:0] m;
        int          lat;
        int          k;
        int          busy_seen;
        m   = model(op, a, b);
        lat = (!op[1] && b == 0) ? 2 : 32;
        @(negedge clk);
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        busy_seen = busy_o ? 1 : 0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        op_i      = 2'($urandom);
        k = 0;
        while (!ready_o && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (busy_o) busy_seen++;
        end
        checkOutput({tag, " latency"}, 64'(k), 64'(lat));
        checkOutput({tag, " busy"}, 64'(busy_seen), 64'(lat));
        checkOutput({tag, " result"}, result_o, m[63:0]);
        checkOutput({tag, " dbz"}, 64'(dbz_o), 64'(m[64]));
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        checkOutput({tag, " hold"}, {ready_o, result_o[62:0]}, {1'b1, m[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int          k;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;

        rst       = 1'b0;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        op_i      = 2'b00;
        opdata1_i = '0;
        opdata2_i = '0;
        start8    = 1'b0;
        op8       = 2'b00;
        a8        = '0;
        b8        = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", {result_o[60:0], ready_o, busy_o, dbz_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(2'b01, 32'd100, 32'd7, "divu 100/7");
        applyStimulus(2'b00, 32'hFFFFFFF9, 32'd2, "div -7/2");
        applyStimulus(2'b00, 32'd7, 32'hFFFFFFFE, "div 7/-2");
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'd2, "mult -1*2");
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'd2, "multu");
        applyStimulus(2'b00, 32'h80000000, 32'hFFFFFFFF, "div minneg/-1");
        applyStimulus(2'b01, 32'd5, 32'd0, "divu 5/0");

        // Reset in the middle of a multiply, right after a zero-divisor result.
        @(negedge clk);
        op_i      = 2'b10;
        opdata1_i = 32'd1234;
        opdata2_i = 32'd5678;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset mid-calc", {result_o[60:0], ready_o, busy_o, dbz_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Annul after ten CALC cycles; no result may appear.
        @(negedge clk);
        op_i      = 2'b01;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("annul idle", {62'd0, ready_o, busy_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("annul no ready", {62'd0, ready_o, busy_o}, 64'd0);
        applyStimulus(2'b01, 32'd9, 32'd3, "divu 9/3");

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 300);
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, "random");
        end

        // Narrow instance: 8-bit unsigned multiply and signed wrap case.
        @(negedge clk);
        op8    = 2'b11;
        a8     = 8'd255;
        b8     = 8'd255;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (!ready8 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("w8 multu latency", 64'(k), 64'd8);
        checkOutput("w8 multu result", 64'(res8), 64'h0000_0000_0000_FE01);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        op8    = 2'b00;
        a8     = 8'h80;
        b8     = 8'hFF;
        start8 = 1'b1;
        @(posedge clk);
        k = 0;
        while (!ready8 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("w8 div wrap", {47'd0, dbz8, res8}, 64'h0000_0000_0000_0080);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
